// File: rtl/signed_mult_seq_if.sv
// Handshake/operand bundle for signed_mult_seq.
// SIGNED_MODE_SEL_EN adds the per-operation Is_signed select.
interface signed_mult_seq_if #(
  parameter int WIDTH = 8
);
  logic                   Start;
  logic [WIDTH-1:0]       Multiplicand;
  logic [WIDTH-1:0]       Multiplier;
`ifdef SIGNED_MODE_SEL_EN
  logic                   Is_signed;
`endif
  logic [2*WIDTH-1:0]     Product;
  logic                   X;
  logic                   Busy;
  logic                   Done;

  modport master (
    output Start, Multiplicand, Multiplier,
`ifdef SIGNED_MODE_SEL_EN
    output Is_signed,
`endif
    input  Product, X, Busy, Done
  );

  modport slave (
    input  Start, Multiplicand, Multiplier,
`ifdef SIGNED_MODE_SEL_EN
    input  Is_signed,
`endif
    output Product, X, Busy, Done
  );
endinterface

// File: rtl/signed_mult_seq.sv
// W-bit sequential add/shift multiplier, {X,A,B} shift chain, 2W-cycle latency.
// Define SIGNED_MODE_SEL_EN to add a per-operation signed/unsigned select.
module signed_mult_seq #(
  parameter int WIDTH = 8
) (
  input  logic              Clk,
  input  logic              Reset_n,
  signed_mult_seq_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH-1);

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_SHIFT, S_DONE} state_t;

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_s;
  logic             r_x;
  logic [CW-1:0]    r_cnt;
  logic             w_sgn;
  logic             w_sub;
  logic [WIDTH:0]   w_ext_a, w_ext_s, w_sum;

`ifdef SIGNED_MODE_SEL_EN
  logic r_sgn;
  always_ff @(posedge Clk) begin
    if (!Reset_n)                          r_sgn <= 1'b0;
    else if (r_state == S_IDLE && bus.Start) r_sgn <= bus.Is_signed;
  end
  assign w_sgn = r_sgn;
`else
  assign w_sgn = 1'b1;
`endif

  always_ff @(posedge Clk) begin
    if (!Reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.Start) w_next = S_ADD;
      S_ADD:   w_next = S_SHIFT;
      S_SHIFT: w_next = (r_cnt == LAST) ? S_DONE : S_ADD;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // The MSB of the multiplier carries weight -2^(W-1) in two's complement,
  // hence the subtract on the last partial product.
  assign w_sub   = w_sgn && (r_cnt == LAST);
  assign w_ext_a = w_sgn ? {r_a[WIDTH-1], r_a} : {1'b0, r_a};
  assign w_ext_s = w_sgn ? {r_s[WIDTH-1], r_s} : {1'b0, r_s};
  assign w_sum   = w_ext_a + (w_sub ? ~w_ext_s : w_ext_s) + {{WIDTH{1'b0}}, w_sub};

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_s   <= '0;
      r_x   <= 1'b0;
      r_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.Start) begin
          r_s   <= bus.Multiplicand;
          r_b   <= bus.Multiplier;
          r_a   <= '0;
          r_x   <= 1'b0;
          r_cnt <= '0;
        end
        S_ADD: if (r_b[0]) {r_x, r_a} <= w_sum;
        S_SHIFT: begin
          {r_x, r_a, r_b} <= {(w_sgn & r_x), r_x, r_a, r_b[WIDTH-1:1]};
          r_cnt           <= r_cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.Product = {r_a, r_b};
  assign bus.X       = r_x;
  assign bus.Busy    = (r_state != S_IDLE);
  assign bus.Done    = (r_state == S_DONE);
endmodule
